// File: rtl/timer_counter.sv
// Memory-mapped programmable down-counter with one-shot and auto-reload modes.
// Registers are CTRL, PRESET and COUNT. An interrupt flag is masked by CTRL.IM.
module timer_counter #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CNT  = 2'd2;
    localparam logic [1:0] S_INT  = 2'd3;

    logic        en;
    logic [1:0]  mode;
    logic        im;
    logic [31:0] preset;
    logic [31:0] count;
    logic [1:0]  state;
    logic        flag;

    logic        hit;
    logic        wr_ctrl;
    logic        wr_preset;
    logic        auto_reload;
    logic        flag_set;
    logic        unused_addr;

    assign hit         = (addr[31:4] == BASE_ADDR[31:4]);
    assign wr_ctrl     = hit && (byteen == 4'b1111) && (addr[3:2] == 2'd0);
    assign wr_preset   = hit && (byteen == 4'b1111) && (addr[3:2] == 2'd1);
    assign auto_reload = (mode == 2'b01);
    assign flag_set    = (state == S_CNT) && en && (count <= 32'd1);
    assign unused_addr = ^addr[1:0];

    // A bus write to CTRL takes priority over the end-of-run EN clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en   <= 1'b0;
            mode <= 2'b00;
            im   <= 1'b0;
        end else if (wr_ctrl) begin
            en   <= wdata[0];
            mode <= wdata[2:1];
            im   <= wdata[3];
        end else if ((state == S_INT) && !auto_reload) begin
            en   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            preset <= 32'd0;
        end else if (wr_preset) begin
            preset <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            count <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en) state <= S_LOAD;
                end
                S_LOAD: begin
                    count <= preset;
                    state <= S_CNT;
                end
                S_CNT: begin
                    if (!en) begin
                        state <= S_IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        count <= 32'd0;
                        state <= S_INT;
                    end
                end
                S_INT: begin
                    state <= auto_reload ? S_LOAD : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Setting the flag wins over a same-cycle clearing bus write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flag <= 1'b0;
        end else if (flag_set) begin
            flag <= 1'b1;
        end else if (wr_ctrl || wr_preset) begin
            flag <= 1'b0;
        end else if ((state == S_INT) && auto_reload) begin
            flag <= 1'b0;
        end
    end

    assign irq = flag & im;

    always_comb begin
        rdata = 32'd0;
        if (hit) begin
            case (addr[3:2])
                2'd0:    rdata = {28'd0, im, mode, en};
                2'd1:    rdata = preset;
                2'd2:    rdata = count;
                default: rdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_counter.sv
// Directed and randomized bench for timer_counter; expected COUNT/irq/CTRL
// come from closed-form arithmetic on cycles elapsed since EN was written.
module tb_timer_counter;

    localparam logic [31:0] A_CTRL  = 32'h0000_7F00;
    localparam logic [31:0] A_PRE   = 32'h0000_7F04;
    localparam logic [31:0] A_CNT   = 32'h0000_7F08;
    localparam logic [31:0] A_RSV   = 32'h0000_7F0C;
    localparam logic [31:0] A_MISS  = 32'h0000_7F10;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;

    timer_counter dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .byteen (byteen),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        addr   = a;
        wdata  = d;
        byteen = be;
        @(posedge clk);
        #1;
        byteen = 4'b0000;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic chk_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        chk(tag, d, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        chk(tag, {31'd0, irq}, {31'd0, exp});
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick(1);
    endtask

    // Program PRESET=n and CTRL, then compare every cycle against the timeline
    // t = edges elapsed since the CTRL write.
    task automatic run_model(input string tag, input int n, input logic [1:0] mode,
                             input logic im, input int cycles);
        int m, per, d, u;
        logic [31:0] e_cnt, e_ctrl;
        logic e_irq, skip_cnt;
        m = (n < 1) ? 1 : n;
        per = m + 2;
        do_reset();
        wr(A_PRE, n, 4'b1111);
        wr(A_CTRL, {28'd0, im, mode, 1'b1}, 4'b1111);
        for (int t = 1; t <= cycles; t++) begin
            tick(1);
            skip_cnt = 1'b0;
            e_ctrl = {28'd0, im, mode, 1'b1};
            if (t < 2) begin
                e_cnt = 0;
                e_irq = 1'b0;
            end else if (mode != 2'b01) begin
                d = t - 2;
                e_cnt = (d < n) ? n - d : 0;
                e_irq = im && (d >= m);
                if (d >= m + 1) e_ctrl = {28'd0, im, mode, 1'b0};
            end else begin
                u = (t - 2) % per;
                e_cnt = (u < n) ? n - u : 0;
                e_irq = im && (u == m);
                skip_cnt = (u == per - 1);
            end
            if (!skip_cnt) chk_reg({tag, "_count"}, A_CNT, e_cnt);
            chk_reg({tag, "_ctrl"}, A_CTRL, e_ctrl);
            chk_irq({tag, "_irq"}, e_irq);
        end
    endtask

    initial begin
        logic [31:0] d;
        reset  = 1'b1;
        addr   = 32'd0;
        byteen = 4'b0000;
        wdata  = 32'd0;
        #2 reset = 1'b0;

        // Reset and decode
        tick(3);
        chk_reg("rst_ctrl", A_CTRL, 32'd0);
        chk_reg("rst_pre", A_PRE, 32'd0);
        chk_reg("rst_cnt", A_CNT, 32'd0);
        chk_irq("rst_irq", 1'b0);
        reset = 1'b1;
        tick(1);
        wr(A_CTRL, 32'hFFFF_FFFF, 4'b1111);
        chk_reg("ctrl_mask", A_CTRL, 32'h0000_000F);
        chk_reg("rsv_read", A_RSV, 32'd0);
        chk_reg("miss_read", A_MISS, 32'd0);

        // One-shot, PRESET=5
        do_reset();
        wr(A_PRE, 32'd5, 4'b1111);
        wr(A_CTRL, 32'h9, 4'b1111);
        tick(2);
        chk_reg("os_e2_cnt", A_CNT, 32'd5);
        tick(4);
        chk_reg("os_e6_cnt", A_CNT, 32'd1);
        chk_irq("os_e6_irq", 1'b0);
        tick(1);
        chk_irq("os_e7_irq", 1'b1);
        tick(1);
        chk_reg("os_e8_ctrl", A_CTRL, 32'h8);
        tick(3);
        chk_irq("os_hold_irq", 1'b1);
        wr(A_CTRL, 32'h0, 4'b1111);
        chk_irq("os_clr_irq", 1'b0);

        // Auto-reload, PRESET=3, four periods
        run_model("ar3", 3, 2'b01, 1'b1, 22);

        // Write filtering
        do_reset();
        wr(A_PRE, 32'h1234_5678, 4'b1111);
        wr(A_PRE, 32'hFFFF_FFFF, 4'b0011);
        chk_reg("flt_partial", A_PRE, 32'h1234_5678);
        wr(A_CNT, 32'h0000_00AB, 4'b1111);
        chk_reg("flt_count", A_CNT, 32'd0);
        wr(32'h1000_7F00, 32'hF, 4'b1111);
        chk_reg("flt_window", A_CTRL, 32'd0);

        // PRESET write mid-count applies at the next reload
        do_reset();
        wr(A_PRE, 32'd4, 4'b1111);
        wr(A_CTRL, 32'hB, 4'b1111);
        tick(2);
        chk_reg("mid_e2_cnt", A_CNT, 32'd4);
        wr(A_PRE, 32'd10, 4'b1111);
        chk_reg("mid_e3_cnt", A_CNT, 32'd3);
        tick(3);
        chk_reg("mid_e6_cnt", A_CNT, 32'd0);
        chk_irq("mid_e6_irq", 1'b1);
        tick(2);
        chk_reg("mid_reload", A_CNT, 32'd10);

        // Clearing EN at COUNT=2 freezes the count
        do_reset();
        wr(A_PRE, 32'd4, 4'b1111);
        wr(A_CTRL, 32'h9, 4'b1111);
        tick(3);
        chk_reg("stop_e3_cnt", A_CNT, 32'd3);
        wr(A_CTRL, 32'h8, 4'b1111);
        tick(4);
        chk_reg("stop_hold", A_CNT, 32'd2);
        chk_irq("stop_irq", 1'b0);

        // CTRL write during INT beats the EN clear
        do_reset();
        wr(A_PRE, 32'd2, 4'b1111);
        wr(A_CTRL, 32'h9, 4'b1111);
        tick(4);
        chk_irq("col_int_irq", 1'b1);
        wr(A_CTRL, 32'h9, 4'b1111);
        chk_reg("col_ctrl", A_CTRL, 32'h9);
        chk_irq("col_irq", 1'b0);

        // Asynchronous reset mid-count
        do_reset();
        wr(A_PRE, 32'd20, 4'b1111);
        wr(A_CTRL, 32'h9, 4'b1111);
        tick(5);
        chk_reg("ar_pre_cnt", A_CNT, 32'd17);
        reset = 1'b0;
        #1;
        chk_reg("ar_cnt", A_CNT, 32'd0);
        chk_reg("ar_ctrl", A_CTRL, 32'd0);
        chk_irq("ar_irq", 1'b0);
        reset = 1'b1;
        tick(3);
        chk_reg("ar_idle_cnt", A_CNT, 32'd0);

        // Randomized trials against the timeline model
        for (int i = 0; i < 8; i++) begin
            int n;
            logic [1:0] mode;
            logic im;
            n    = $urandom_range(0, 12);
            mode = 2'($urandom_range(0, 3));
            im   = 1'($urandom_range(0, 1));
            run_model("rnd", n, mode, im, n + 12);
        end

        rd(A_CTRL, d);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped programmable down-counter that sits on the CPU data bus as a responder at the timer window (default base 0x0000_7F00). It accepts word writes driven through the CPU's data address, write data and byte-enable outputs, and returns register contents combinationally for the same-cycle data-read path. Its interrupt output feeds one bit of the CPU's hardware-interrupt vector.

## Interface
- BASE_ADDR, 32'h0000_7F00, 16-byte-aligned window base; only addr[31:4] is compared.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; all state is cleared while low.
- addr  in  32  CPU data address.
- byteen  in  4  CPU write byte-enable; 4'b0000 means no write.
- wdata  in  32  CPU write data, already lane-aligned.
- rdata  out  32  read data, combinational from addr.
- irq  out  1  interrupt request to the CPU.

## Operation
- Hit: addr[31:4] == BASE_ADDR[31:4]. Register select is addr[3:2]:
  - 0 = CTRL. Bit 0 is EN, bits 2:1 are MODE, bit 3 is IM. Bits 31:4 always read 0.
  - 1 = PRESET (32-bit).
  - 2 = COUNT (read-only).
  - 3 = reserved; reads 0.
- Write occurs only when hit and byteen == 4'b1111.
  - Any other non-zero byteen is ignored; the CPU raises AdES for it.
  - Writes to COUNT or to the reserved slot are ignored.
- rdata is 0 when addr misses the window.
- MODE 2'b00 is one-shot. MODE 2'b01 is auto-reload. MODE 2'b1x behaves as 2'b00.
- FSM has four states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN = 1, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - If EN = 0, go to IDLE; COUNT holds.
    - Else if COUNT > 1, COUNT <= COUNT − 1.
    - Else (COUNT is 0 or 1), COUNT <= 0, set flag, go to INT.
  - INT:
    - MODE 00: EN <= 0, go to IDLE. flag stays set.
    - MODE 01: clear flag, go to LOAD.
- irq = flag & IM, where IM is the current CTRL.IM.
- A bus write to CTRL or PRESET clears flag.
- Simultaneous events:
  - A bus CTRL write in the same cycle that INT clears EN: the bus write wins.
  - A bus write that clears flag in the same cycle CNT sets it: set wins.
- A PRESET write mid-count does not change COUNT; it takes effect at the next LOAD.
- Counting is unsigned. There is no wrap: COUNT never decrements below 0.

## Timing
- Reset values: CTRL = 0, PRESET = 0, COUNT = 0, state = IDLE, flag = 0, irq = 0. rdata for any in-window address is 0.
- A register write is visible on rdata in the cycle after edge E0, the edge that accepts the write.
- Enable sequence, with EN written at E0:
  - E1: state = LOAD.
  - E2: COUNT = PRESET = N, state = CNT.
  - E2+k: COUNT = N − k, for 1 ≤ k ≤ N−1.
  - E2+N: COUNT = 0, state = INT, irq = 1 (if IM = 1).
- Edge cases of the sequence:
  - N = 0: INT is reached at E3.
  - N = 1: INT is reached at E3.
- MODE 01:
  - irq is high for exactly one cycle, between edges E2+N and E2+N+1.
  - COUNT reloads at E2+N+2.
  - Period is N+2 cycles for N ≥ 1.
- MODE 00: irq stays high until a CTRL or PRESET write, or until reset.
- Clearing EN while in CNT: state = IDLE at the next edge.
- Reset asserted mid-count: all outputs and state clear immediately (asynchronous); counting restarts only after EN is written again.

## Test plan
- Reset and decode:
  - Hold reset low, then read 0x7F00, 0x7F04 and 0x7F08 -> all 0, irq = 0.
  - Write 0xFFFF_FFFF to CTRL -> read back 0x0000_000F.
  - Read 0x7F0C and 0x7F10 -> 0.
- One-shot:
  - Write PRESET = 5, then CTRL = 0x9 (EN, IM, mode 00) at E0.
  - COUNT reads 5 after E2 and 1 after E6; irq rises at E7 and stays high.
  - CTRL reads 0x8 after E8.
  - A write of CTRL = 0 drops irq at the next edge.
- Auto-reload:
  - Write PRESET = 3, then CTRL = 0xB.
  - irq pulses one cycle wide, every 5 cycles, for at least 4 periods.
  - COUNT sequence is 3, 2, 1, 0, −, 3, …
- Write filtering:
  - byteen = 4'b0011 to PRESET -> PRESET unchanged.
  - Full write to 0x7F08 -> COUNT unchanged.
  - Full write to 0x7F00 with addr[31:4] ≠ window -> CTRL unchanged.
- Mid-count events:
  - Write PRESET = 10 while counting from 4 -> current run still ends at 0; the next reload loads 10.
  - Clear EN at COUNT = 2 -> COUNT holds 2 and no irq.
- Collision and async reset:
  - Write CTRL = 0x9 in the cycle the FSM is in INT (mode 00) -> EN reads 1 afterwards.
  - Pulse reset low for a sub-cycle interval mid-count -> COUNT, CTRL and irq are 0 immediately.
